// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for a 15-bit serial LFSR: optional seed load, prime, then a valid/ready bit stream.
// Optional zero-seed guard is enabled by defining LFSR_SEQ_CTRL_ZERO_GUARD_EN.
module lfsr_seq_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             seed_load,
   input  logic [14:0]      seed,
   input  logic [CNT_W-1:0] length,
   output logic             lfsr_enable,
   output logic             lfsr_load,
   output logic             lfsr_data_in,
   input  logic             lfsr_data_out,
   output logic             bit_out,
   output logic             bit_valid,
   input  logic             bit_ready,
   output logic             busy,
   output logic             done,
   output logic             seed_err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_PRIME = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           r_state;
   logic [3:0]       r_idx;
   logic [CNT_W-1:0] r_remain;
   logic [14:0]      r_seed;

   logic w_in_load;
   logic w_in_prime;
   logic w_in_run;
   logic w_accept;
   logic w_last;

   assign w_in_load  = (r_state == S_LOAD);
   assign w_in_prime = (r_state == S_PRIME);
   assign w_in_run   = (r_state == S_RUN);
   assign w_accept   = w_in_run && bit_ready;
   assign w_last     = (r_remain == CNT_W'(1));

   // The seed shadow shifts left during LOAD so its MSB is always the next bit to send.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_idx    <= 4'd0;
         r_remain <= '0;
         r_seed   <= 15'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_remain <= length;
                  r_idx    <= 4'd14;
                  r_seed   <= seed;
`ifdef LFSR_SEQ_CTRL_ZERO_GUARD_EN
                  if (seed_load && (seed == 15'd0)) begin
                     r_seed <= 15'h0001;
                  end
`endif
                  if (length == '0) begin
                     r_state <= S_DONE;
                  end else if (seed_load) begin
                     r_state <= S_LOAD;
                  end else begin
                     r_state <= S_PRIME;
                  end
               end
            end
            S_LOAD: begin
               r_seed <= {r_seed[13:0], 1'b0};
               if (r_idx == 4'd0) begin
                  r_state <= S_PRIME;
               end else begin
                  r_idx <= r_idx - 4'd1;
               end
            end
            S_PRIME: begin
               r_state <= S_RUN;
            end
            S_RUN: begin
               if (w_accept) begin
                  if (w_last) begin
                     r_state <= S_DONE;
                  end else begin
                     r_remain <= r_remain - CNT_W'(1);
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef LFSR_SEQ_CTRL_ZERO_GUARD_EN
   logic r_seed_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_seed_err <= 1'b0;
      end else begin
         r_seed_err <= (r_state == S_IDLE) && start && seed_load && (seed == 15'd0);
      end
   end

   assign seed_err = r_seed_err;
`else
   assign seed_err = 1'b0;
`endif

   // The final accepted bit leaves the LFSR parked so a follow-on request resumes seamlessly.
   assign lfsr_load    = w_in_load;
   assign lfsr_data_in = w_in_load & r_seed[14];
   assign lfsr_enable  = w_in_load | w_in_prime | (w_accept & ~w_last);

   assign bit_valid = w_in_run;
   assign bit_out   = w_in_run & lfsr_data_out;
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: a behavioural serial LFSR stub plus a stream-level reference model.
// Expectations follow LFSR_SEQ_CTRL_ZERO_GUARD_EN when it is defined for the build.
module tb_lfsr_seq_ctrl;

   localparam int CNT_W = 16;
   localparam int XN    = 4096;

   logic             clk;
   logic             reset;
   logic             start;
   logic             seed_load;
   logic [14:0]      seed;
   logic [CNT_W-1:0] length;
   logic             lfsr_enable;
   logic             lfsr_load;
   logic             lfsr_data_in;
   logic             lfsr_data_out;
   logic             bit_out;
   logic             bit_valid;
   logic             bit_ready;
   logic             busy;
   logic             done;
   logic             seed_err;

   logic             lfsr_rst;
   logic [15:1]      lf;

   int n_cmp;
   int n_err;
   int ptr;
   bit xs [XN];

   lfsr_seq_ctrl #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .seed_load    (seed_load),
      .seed         (seed),
      .length       (length),
      .lfsr_enable  (lfsr_enable),
      .lfsr_load    (lfsr_load),
      .lfsr_data_in (lfsr_data_in),
      .lfsr_data_out(lfsr_data_out),
      .bit_out      (bit_out),
      .bit_valid    (bit_valid),
      .bit_ready    (bit_ready),
      .busy         (busy),
      .done         (done),
      .seed_err     (seed_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Serial LFSR stub: loading shifts data_in toward data[15]; running emits data[1].
   always @(posedge clk) begin
      if (lfsr_rst) begin
         lf            <= 15'h2a5b;
         lfsr_data_out <= 1'b0;
      end else if (lfsr_enable) begin
         if (lfsr_load) begin
            lf <= {lf[14:1], lfsr_data_in};
         end else begin
            lfsr_data_out <= lf[1];
            lf            <= {lf[1] ^ lf[2], lf[15:2]};
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected bit stream from a seed: seed bits LSB first, then x[k] = x[k-15] ^ x[k-14].
   task automatic gen_stream(input logic [14:0] sd);
      for (int k = 0; k < XN; k++) begin
         if (k < 15) xs[k] = sd[k];
         else        xs[k] = xs[k-15] ^ xs[k-14];
      end
      ptr = 0;
   endtask

   task automatic run_req(input logic sl, input logic [14:0] sd, input int len,
                          input int mode, output logic [63:0] got);
      int  cyc;
      int  nacc;
      int  first_valid;
      int  last_acc;
      bit  saw_done;
      bit  prev_stall;
      logic prev_bit;
      logic [14:0] eff;
      bit  exp_err;
      exp_err = 1'b0;
      eff     = sd;
`ifdef LFSR_SEQ_CTRL_ZERO_GUARD_EN
      if (sl && sd == 15'd0) begin
         eff     = 15'h0001;
         exp_err = 1'b1;
      end
`endif
      if (sl) gen_stream(eff);
      got         = '0;
      start       = 1'b1;
      seed_load   = sl;
      seed        = sd;
      length      = CNT_W'(len);
      @(posedge clk); #1;
      start       = 1'b0;
      seed        = 15'($urandom);
      length      = CNT_W'($urandom);
      seed_load   = 1'($urandom);
      cyc         = 1;
      nacc        = 0;
      first_valid = -1;
      last_acc    = 0;
      saw_done    = 1'b0;
      prev_stall  = 1'b0;
      prev_bit    = 1'b0;
      while (!saw_done && cyc < 2000) begin
         case (mode)
            0:       bit_ready = 1'b1;
            1:       bit_ready = (cyc % 2) == 0;
            default: bit_ready = 1'($urandom);
         endcase
         #1;
         if (cyc == 1) chk("seed_err_c1", 32'(seed_err), 32'(exp_err));
         else          chk("seed_err_quiet", 32'(seed_err), 32'd0);
         if (done) begin
            saw_done = 1'b1;
            chk("done_nbits", nacc, len);
            chk("done_cycle", cyc, (len == 0) ? 1 : last_acc + 1);
            chk("done_valid_low", 32'(bit_valid), 32'd0);
            if (len == 0) chk("len0_enable", 32'(lfsr_enable), 32'd0);
         end else begin
            chk("busy_active", 32'(busy), 32'd1);
            if (bit_valid) begin
               if (first_valid < 0) begin
                  first_valid = cyc;
                  chk("first_valid", cyc, sl ? 17 : 2);
               end
               chk("bit", 32'(bit_out), 32'(xs[ptr % XN]));
               if (prev_stall) chk("stall_hold", 32'(bit_out), 32'(prev_bit));
               if (bit_ready) begin
                  chk("en_accept", 32'(lfsr_enable), 32'((nacc + 1) < len));
                  if (nacc < 64) got[nacc] = bit_out;
                  nacc++;
                  ptr++;
                  last_acc = cyc;
               end else begin
                  chk("en_stall", 32'(lfsr_enable), 32'd0);
               end
               prev_stall = !bit_ready;
               prev_bit   = bit_out;
            end
            @(posedge clk); #1;
            cyc++;
         end
      end
      chk("no_timeout", 32'(saw_done), 32'd1);
      bit_ready = 1'b0;
      @(posedge clk); #1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_valid", 32'(bit_valid), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_en"},    32'(lfsr_enable),  32'd0);
      chk({tag, "_load"},  32'(lfsr_load),    32'd0);
      chk({tag, "_din"},   32'(lfsr_data_in), 32'd0);
      chk({tag, "_bit"},   32'(bit_out),      32'd0);
      chk({tag, "_valid"}, 32'(bit_valid),    32'd0);
      chk({tag, "_busy"},  32'(busy),         32'd0);
      chk({tag, "_done"},  32'(done),         32'd0);
      chk({tag, "_serr"},  32'(seed_err),     32'd0);
   endtask

   initial begin
      logic [63:0] got;
      logic [3:0]  exp_zero;
      n_cmp     = 0;
      n_err     = 0;
      ptr       = 0;
      reset     = 1'b1;
      lfsr_rst  = 1'b1;
      start     = 1'b0;
      seed_load = 1'b0;
      seed      = 15'd0;
      length    = '0;
      bit_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      reset    = 1'b0;
      lfsr_rst = 1'b0;
      @(posedge clk); #1;

      run_req(1'b1, 15'h0005, 4, 0, got);
      chk("seed5_bits", 32'(got[3:0]), 32'h5);
      run_req(1'b1, 15'h0005, 4, 1, got);
      chk("seed5_alt_bits", 32'(got[3:0]), 32'h5);

      run_req(1'b1, 15'h0005, 2, 0, got);
      chk("split_first", 32'(got[1:0]), 32'h1);
      run_req(1'b0, 15'h7fff, 2, 2, got);
      chk("split_second", 32'(got[1:0]), 32'h1);

      run_req(1'($urandom), 15'($urandom), 0, 0, got);

      // Abort during LOAD: reset sampled at the end of load cycle 8.
      start     = 1'b1;
      seed_load = 1'b1;
      seed      = 15'h1357;
      length    = CNT_W'(10);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("abort_in_load", 32'(lfsr_load), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk_all_zero("abort");
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done), 32'd0);
      run_req(1'b1, 15'h0005, 4, 2, got);
      chk("after_abort_bits", 32'(got[3:0]), 32'h5);

`ifdef LFSR_SEQ_CTRL_ZERO_GUARD_EN
      exp_zero = 4'b0001;
`else
      exp_zero = 4'b0000;
`endif
      run_req(1'b1, 15'd0, 4, 0, got);
      chk("zero_seed_bits", 32'(got[3:0]), 32'(exp_zero));

      for (int i = 0; i < 24; i++) begin
         run_req((i == 0) ? 1'b1 : 1'($urandom), 15'($urandom),
                 int'($urandom_range(0, 40)), 2, got);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
